// File: rtl/mdu_ctrl.sv
// Multiply/divide unit control: HI/LO registers, fixed-latency MULT/DIV sequencing, pipeline stall.
// MULT*/DIV* occupy MUL_CYCLES/DIV_CYCLES busy cycles; MTHI/MTLO write at once; starts while busy are dropped.
module mdu_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HILOout
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        op_valid, op_long, accept;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, uq, ur, quo, rem;

    assign op_valid = (op >= OP_MULT) && (op <= OP_MTLO);
    assign op_long  = (op >= OP_MULT) && (op <= OP_DIVU);
    assign accept   = start && !cancel && (state_q == IDLE) && op_valid;

    assign busy    = (state_q == RUN);
    assign stall   = d_is_md && (busy || (start && op_long && !cancel));
    assign HILOout = rd_sel ? lo_q : hi_q;

    // Signed results come from magnitudes, so 0x80000000 / -1 wraps to 0x80000000 rem 0.
    always_comb begin
        a_ext  = {{32{(op_q == OP_MULT) & a_q[31]}}, a_q};
        b_ext  = {{32{(op_q == OP_MULT) & b_q[31]}}, b_q};
        prod   = a_ext * b_ext;
        a_neg  = (op_q == OP_DIV) & a_q[31];
        b_neg  = (op_q == OP_DIV) & b_q[31];
        a_mag  = a_neg ? -a_q : a_q;
        b_mag  = b_neg ? -b_q : b_q;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq     = a_mag / b_safe;
        ur     = a_mag % b_safe;
        quo    = (a_neg ^ b_neg) ? -uq : uq;
        rem    = a_neg ? -ur : ur;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MTHI) begin
                        hi_d = A;
                    end else if (op == OP_MTLO) begin
                        lo_d = A;
                    end else begin
                        op_d    = op;
                        a_d     = A;
                        b_d     = B;
                        cnt_d   = (op == OP_MULT || op == OP_MULTU) ? MUL_LAST : DIV_LAST;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    if (op_q == OP_MULT || op_q == OP_MULTU) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (b_q != 32'd0) begin
                        // Divide by zero leaves HI/LO untouched but still burns the full latency.
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed-vector bench for mdu_ctrl with hand-computed HI/LO, latency and stall expectations.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, cancel, rd_sel, d_is_md;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, stall;
    logic [31:0] HILOout;

    int vecs = 0;
    int errs = 0;

    mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .cancel  (cancel),
        .A       (A),
        .B       (B),
        .rd_sel  (rd_sel),
        .d_is_md (d_is_md),
        .busy    (busy),
        .stall   (stall),
        .HILOout (HILOout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        rd_sel = 1'b0;
        #1;
        check({tag, ".hi"}, {32'd0, HILOout}, {32'd0, hi});
        rd_sel = 1'b1;
        #1;
        check({tag, ".lo"}, {32'd0, HILOout}, {32'd0, lo});
    endtask

    // Issue one op, then count busy cycles (bounded) and compare against the expected latency.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles);
        int n;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        op    = 3'd0;
        n     = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check({tag, ".cycles"}, 64'(n), 64'(exp_cycles));
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; op = 3'd0; cancel = 1'b0;
        A = 32'd0; B = 32'd0; rd_sel = 1'b0; d_is_md = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state and combinational stall term
        check("rst.busy", {63'd0, busy}, 64'd0);
        check_hilo("rst", 32'h0, 32'h0);
        d_is_md = 1'b1; start = 1'b1; op = 3'd3; cancel = 1'b0;
        #1;
        check("rst.stall_q", {63'd0, stall}, 64'd1);
        cancel = 1'b1;
        #1;
        check("rst.stall_cancel", {63'd0, stall}, 64'd0);
        tick();
        check("cancel_div.busy", {63'd0, busy}, 64'd0);
        start = 1'b0; cancel = 1'b0; d_is_md = 1'b0;
        #1;
        check("idle.stall", {63'd0, stall}, 64'd0);

        run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 5);
        check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 5);
        check_hilo("multu", 32'h00000001, 32'hFFFFFFFE);
        run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 10);
        check_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu0", 3'd4, 32'd7, 32'd0, 10);
        check_hilo("divu0", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10);
        check_hilo("div_ovf", 32'h0, 32'h80000000);
        run_op("divu", 3'd4, 32'd100, 32'd7, 10);
        check_hilo("divu", 32'd2, 32'd14);
        run_op("div_negb", 3'd3, 32'd7, 32'hFFFFFFFE, 10);
        check_hilo("div_negb", 32'd1, 32'hFFFFFFFD);

        // MTLO cancelled, then accepted; MTHI
        start = 1'b1; op = 3'd6; A = 32'h12345678; cancel = 1'b1;
        tick();
        check("mtlo_cancel.busy", {63'd0, busy}, 64'd0);
        check_hilo("mtlo_cancel", 32'd1, 32'hFFFFFFFD);
        cancel = 1'b0;
        tick();
        start = 1'b0;
        check("mtlo.busy", {63'd0, busy}, 64'd0);
        check_hilo("mtlo", 32'd1, 32'h12345678);
        start = 1'b1; op = 3'd5; A = 32'hCAFEBABE;
        tick();
        start = 1'b0;
        check_hilo("mthi", 32'hCAFEBABE, 32'h12345678);

        // ops 0 and 7 are no-ops
        start = 1'b1; op = 3'd0; A = 32'h1; B = 32'h1;
        tick();
        check("op0.busy", {63'd0, busy}, 64'd0);
        op = 3'd7;
        tick();
        start = 1'b0;
        check("op7.busy", {63'd0, busy}, 64'd0);
        check_hilo("op07", 32'hCAFEBABE, 32'h12345678);

        // Stall across a DIV with an ignored mid-run start
        d_is_md = 1'b1; start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd10;
        #1;
        check("stall.start", {63'd0, stall}, 64'd1);
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            check("stall.run", {63'd0, stall}, 64'd1);
            if (n == 3) begin
                start = 1'b1; op = 3'd1; A = 32'd2; B = 32'd2;
            end else begin
                start = 1'b0; op = 3'd0;
            end
            n++;
            tick();
        end
        start = 1'b0; op = 3'd0;
        #1;
        check("stall.cycles", 64'(n), 64'd10);
        check("stall.after", {63'd0, stall}, 64'd0);
        check("stall.busy_after", {63'd0, busy}, 64'd0);
        check_hilo("stall_div", 32'd0, 32'd10);
        d_is_md = 1'b0;

        // cancel during RUN does not abort
        start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd4;
        tick();
        start = 1'b0; op = 3'd0;
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n = 2;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check("cancel_run.cycles", 64'(n), 64'd5);
        check_hilo("cancel_run", 32'd0, 32'd12);

        // Reset in busy cycle 3 discards the MULT
        start = 1'b1; op = 3'd1; A = 32'd5; B = 32'd6;
        tick();
        start = 1'b0; op = 3'd0;
        check("rstrun.busy1", {63'd0, busy}, 64'd1);
        tick();
        tick();
        check("rstrun.busy3", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstrun.busy", {63'd0, busy}, 64'd0);
        check_hilo("rstrun", 32'd0, 32'd0);
        tick();
        check("rstrun.stay_idle", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
